// File: rtl/count_mem_reader_if.sv
// Bus bundle for count_mem_reader: sample write strobe, registered valid/ready
// read port, and buffer health status.
interface count_mem_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_seq_err;
  logic [ADDR_W:0]   level;
  logic              full;
  logic              empty;
  logic [7:0]        overflow_cnt;
  logic [7:0]        seq_err_cnt;

  modport slave (
    input  wr_en, wr_data, rd_ready,
    output rd_valid, rd_data, rd_seq_err, level, full, empty,
           overflow_cnt, seq_err_cnt
  );

  modport master (
    output wr_en, wr_data, rd_ready,
    input  rd_valid, rd_data, rd_seq_err, level, full, empty,
           overflow_cnt, seq_err_cnt
  );
endinterface

// File: rtl/count_mem_reader.sv
// Circular sample buffer with a registered valid/ready output stage, sequence
// continuity checking and saturating drop / sequence-error counters.
module count_mem_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  count_mem_reader_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_seq_err_q, rd_seq_err_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              have_prev_q, have_prev_d;
  logic [7:0]        ovf_cnt_q, ovf_cnt_d;
  logic [7:0]        seq_cnt_q, seq_cnt_d;

  logic              full_s, empty_s, wr_fire_s, wr_drop_s, load_s, err_s;
  logic [DATA_W-1:0] head_s, expected_s;

  // Full/empty come from the registered pointers only: no bypass, no same-edge relief.
  assign full_s    = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign wr_fire_s = bus.wr_en && !full_s;
  assign wr_drop_s = bus.wr_en && full_s;
  assign load_s    = (!rd_valid_q || bus.rd_ready) && !empty_s;

  assign head_s     = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign expected_s = last_q + DATA_ONE;
  assign err_s      = have_prev_q && (head_s != expected_s);

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire_s) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
    end
  end

  // Next-state for pointers, output stage, sequence tracker and counters.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_valid_d   = rd_valid_q;
    rd_data_d    = rd_data_q;
    rd_seq_err_d = rd_seq_err_q;
    last_d       = last_q;
    have_prev_d  = have_prev_q;
    ovf_cnt_d    = ovf_cnt_q;
    seq_cnt_d    = seq_cnt_q;

    if (wr_fire_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (wr_drop_s && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end

    if (load_s) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      rd_valid_d   = 1'b1;
      rd_data_d    = head_s;
      rd_seq_err_d = err_s;
      last_d       = head_s;
      have_prev_d  = 1'b1;
      if (err_s && (seq_cnt_q != 8'hFF)) begin
        seq_cnt_d = seq_cnt_q + 8'd1;
      end else begin
        seq_cnt_d = seq_cnt_q;
      end
    end else if (rd_valid_q && bus.rd_ready) begin
      rd_valid_d = 1'b0;
    end else begin
      rd_valid_d = rd_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_seq_err_q <= 1'b0;
      last_q       <= '0;
      have_prev_q  <= 1'b0;
      ovf_cnt_q    <= 8'd0;
      seq_cnt_q    <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_seq_err_q <= rd_seq_err_d;
      last_q       <= last_d;
      have_prev_q  <= have_prev_d;
      ovf_cnt_q    <= ovf_cnt_d;
      seq_cnt_q    <= seq_cnt_d;
    end
  end

  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_seq_err   = rd_seq_err_q;
  assign bus.level        = wr_ptr_q - rd_ptr_q;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.overflow_cnt = ovf_cnt_q;
  assign bus.seq_err_cnt  = seq_cnt_q;
endmodule

// File: tb/tb_count_mem_reader.sv
// Self-checking bench for count_mem_reader: a queue-based model of the buffer
// and output stage, compared on every falling edge, plus literal spot checks.
module tb_count_mem_reader;
  logic clk;
  logic rst;

  count_mem_reader_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  count_mem_reader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  bit chk_en;

  // Model state
  logic [7:0] mq[$];
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_err;
  logic [7:0] m_last;
  bit         m_have;
  int         m_ovf;
  int         m_seq;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge pass, then advance the model.
  task automatic cycle(input bit we, input logic [7:0] wd, input bit rdy, input bit r);
    bit was_full, was_empty, ld;
    logic [7:0] v;
    rst          = r;
    bus.wr_en    = we;
    bus.wr_data  = wd;
    bus.rd_ready = rdy;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      m_valid = 0; m_data = 8'h00; m_err = 0;
      m_last = 8'h00; m_have = 0; m_ovf = 0; m_seq = 0;
    end else begin
      was_full  = (mq.size() == 16);
      was_empty = (mq.size() == 0);
      ld = (!m_valid || rdy) && !was_empty;
      if (ld) begin
        v = mq.pop_front();
        m_err = m_have && (v != 8'(m_last + 8'd1));
        if (m_err && m_seq < 255) m_seq++;
        m_last = v; m_have = 1; m_data = v; m_valid = 1;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
      if (we) begin
        if (was_full) begin
          if (m_ovf < 255) m_ovf++;
        end else begin
          mq.push_back(wd);
        end
      end
    end
  endtask

  // Compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", int'(bus.level), mq.size());
      chk("full", int'(bus.full), int'(mq.size() == 16));
      chk("empty", int'(bus.empty), int'(mq.size() == 0));
      chk("rd_valid", int'(bus.rd_valid), int'(m_valid));
      chk("overflow_cnt", int'(bus.overflow_cnt), m_ovf);
      chk("seq_err_cnt", int'(bus.seq_err_cnt), m_seq);
      if (m_valid) begin
        chk("rd_data", int'(bus.rd_data), int'(m_data));
        chk("rd_seq_err", int'(bus.rd_seq_err), int'(m_err));
      end
    end
  end

  initial begin
    n_vec = 0; n_bad = 0; chk_en = 0;
    rst = 1'b1; bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_ready = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk_en = 1;
    chk("reset level", int'(bus.level), 0);
    chk("reset empty", int'(bus.empty), 1);
    chk("reset rd_data", int'(bus.rd_data), 0);

    // Reset mid-stream, with wr_en asserted during reset
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i + 1), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    chk("mid rst level", int'(bus.level), 0);
    chk("mid rst empty", int'(bus.empty), 1);
    chk("mid rst valid", int'(bus.rd_valid), 0);
    chk("mid rst ovf", int'(bus.overflow_cnt), 0);
    chk("mid rst seq", int'(bus.seq_err_cnt), 0);

    // Single write latency
    cycle(1'b1, 8'h2A, 1'b0, 1'b0);
    chk("wr lat level", int'(bus.level), 1);
    chk("wr lat valid0", int'(bus.rd_valid), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("wr lat valid1", int'(bus.rd_valid), 1);
    chk("wr lat data", int'(bus.rd_data), 8'h2A);
    chk("wr lat level0", int'(bus.level), 0);
    chk("wr lat err", int'(bus.rd_seq_err), 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);

    // Fill and overflow
    for (int i = 0; i <= 8'h12; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill full", int'(bus.full), 1);
    chk("fill level", int'(bus.level), 16);
    chk("fill data", int'(bus.rd_data), 8'h00);
    chk("fill ovf", int'(bus.overflow_cnt), 2);

    // Drain, then a gap in the sequence
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain last", int'(bus.rd_data), 8'h10);
    chk("drain err", int'(bus.rd_seq_err), 0);
    cycle(1'b1, 8'h13, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("gap data", int'(bus.rd_data), 8'h13);
    chk("gap err", int'(bus.rd_seq_err), 1);
    chk("gap seq cnt", int'(bus.seq_err_cnt), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap and backpressure
    cycle(1'b1, 8'hFE, 1'b1, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("wrap data fe", int'(bus.rd_data), 8'hFE);
    cycle(1'b1, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    chk("stall data ff", int'(bus.rd_data), 8'hFF);
    chk("stall valid", int'(bus.rd_valid), 1);
    chk("stall level", int'(bus.level), 2);
    for (int i = 2; i <= 8'h13; i++) cycle(1'b1, 8'(i), 1'(i % 2 == 1), 1'b0);
    for (int i = 0; i < 24; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap seq cnt", int'(bus.seq_err_cnt), 0);
    chk("wrap empty", int'(bus.empty), 1);
    chk("wrap last", int'(bus.rd_data), 8'h13);

    // Saturation
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'(i + 8'h14), 1'b0, 1'b0);
    chk("sat ovf", int'(bus.overflow_cnt), 255);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    chk("sat ovf hold", int'(bus.overflow_cnt), 255);
    chk("sat full", int'(bus.full), 1);

    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/count_mem_reader.md
# count_mem_reader

Read-side companion to the free-running 8-bit sample counter and its 16-entry sample memory. It captures counter samples into a 16-deep circular buffer and drains them through a registered valid/ready output port. Each drained sample is checked for sequence continuity (previous + 1, mod 256). Overflow drops and sequence errors are counted so a Verisocks-driven bench can query buffer health over the socket.

## Interface
- DATA_W, 8, sample width in bits
- ADDR_W, 4, buffer address width; depth = 2**ADDR_W = 16
- clk  in  1  sample clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  sample strobe from the counter side
- wr_data  in  DATA_W  counter sample
- rd_valid  out  1  output stage holds a sample
- rd_ready  in  1  consumer accepts when rd_valid & rd_ready at posedge
- rd_data  out  DATA_W  output sample
- rd_seq_err  out  1  rd_data is not the previous loaded sample + 1; qualified by rd_valid
- level  out  ADDR_W+1  buffer occupancy, 0..16, output stage excluded
- full  out  1  level == 16
- empty  out  1  level == 0
- overflow_cnt  out  8  dropped writes, saturating at 255
- seq_err_cnt  out  8  loads with rd_seq_err set, saturating at 255

## Operation
- Buffer pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits; the MSB is the wrap bit.
  - full when the addresses are equal and the wrap bits differ; empty when both are equal.
  - level = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- Write:
  - If wr_en and not full, store wr_data at wr_ptr[ADDR_W-1:0] and increment wr_ptr.
  - If wr_en and full, drop the sample, leave the memory untouched, and increment overflow_cnt (saturating).
- Output-stage load:
  - The load condition is (!rd_valid | rd_ready) & !empty.
  - On load: rd_data <= mem[rd_ptr]; rd_valid <= 1; rd_ptr increments.
  - If the load condition fails and rd_valid & rd_ready, then rd_valid <= 0.
  - While rd_valid & !rd_ready, rd_data and rd_seq_err hold.
- Sequence check, evaluated at load:
  - expected = last_loaded + 1, mod 2**DATA_W; 255 -> 0 is legal.
  - rd_seq_err <= have_prev & (loaded value != expected).
  - Then last_loaded <= loaded value and have_prev <= 1.
  - seq_err_cnt increments (saturating) on every load where the error is set.
  - The first load after reset is never flagged.
- Full and empty are decided from registered state at the start of the cycle.
  - A write to a full buffer is dropped even if a load frees a slot on the same edge.
  - A load from an empty buffer never occurs, even if a write lands on the same edge. There is no bypass path.
- Simultaneous write and load when neither full nor empty: both happen and level is unchanged.

## Timing
- Reset, at the first posedge with rst=1, regardless of activity in flight:
  - rd_valid=0, rd_data=0, rd_seq_err=0, level=0, full=0, empty=1, overflow_cnt=0, seq_err_cnt=0.
  - Pointers, last_loaded and have_prev are cleared.
  - Memory contents are not reset. An in-flight output word is discarded.
- Write latency:
  - A sample written at edge N counts in level/empty after edge N.
  - It is loaded into the output stage at edge N+1 at the earliest, so rd_valid rises after edge N+1.
- Throughput:
  - With rd_ready held high and writes every cycle, one sample per cycle is sustained.
  - level settles at 1.
- rd_valid never drops without a handshake, and rd_data never changes while rd_valid & !rd_ready.
- All outputs are registered except full, empty and level. Those are combinational from the registered pointers.

## Test plan
- Reset mid-stream:
  - Stimulus: write 5 samples, assert rst for 1 cycle with wr_en=1.
  - Required: the next cycle shows level=0, empty=1, rd_valid=0, and both counters at 0. The wr_en during reset is ignored.
- Single write latency:
  - Stimulus: after reset with rd_ready=0, write 0x2A at edge N.
  - Required: level=1 after N; rd_valid=1, rd_data=0x2A, level=0 after N+1; rd_seq_err=0.
- Fill and overflow:
  - Stimulus: rd_ready=0, write 0x00..0x12 on consecutive cycles.
  - Required: the output holds 0x00 and the buffer holds 0x01..0x10; full=1, level=16.
  - Writes 0x11 and 0x12 are dropped, so overflow_cnt=2.
- Overflow to sequence error:
  - Stimulus: continue the previous test with rd_ready=1, then write 0x13.
  - Required: reads 0x00..0x10 with no error. The next read is 0x13 with rd_seq_err=1 and seq_err_cnt=1.
- Wrap and backpressure:
  - Stimulus: stream 0xFE, 0xFF, 0x00, 0x01 while toggling rd_ready 1-0-1-0.
  - Required: the data order is preserved, rd_data is held during stalls, rd_seq_err stays 0 across 0xFF -> 0x00, and the pointers wrap correctly past 16 entries.
- Saturation:
  - Stimulus: 300 writes into a full buffer.
  - Required: overflow_cnt saturates at 255 and does not wrap.
